// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU: round-robin grant,
// operand registers feeding the ALU, per-op latency counter, and a held response.
//   state | meaning
//   IDLE  | waiting for a request, grant decoded combinationally
//   EXEC  | operands held on the ALU, latency counter running
//   RESP  | result captured, held until the consumer takes it
module alu_arbiter #(
  parameter int SLOW_LAT = 3
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ReqValid0,
  input  logic        ReqValid1,
  output logic        ReqReady0,
  output logic        ReqReady1,
  input  logic [3:0]  ReqOp0,
  input  logic [3:0]  ReqOp1,
  input  logic [31:0] ReqA0,
  input  logic [31:0] ReqB0,
  input  logic [31:0] ReqA1,
  input  logic [31:0] ReqB1,
  output logic [3:0]  ALUControlOut,
  output logic [31:0] AOut,
  output logic [31:0] BOut,
  input  logic [31:0] ALUResultIn,
  input  logic        ZeroIn,
  output logic        RspValid,
  input  logic        RspReady,
  output logic        RspId,
  output logic [31:0] Result,
  output logic        Zero,
  output logic        Busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] SLOW_LOAD = 4'(SLOW_LAT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       fav1;
  logic       grant1;
  logic       take;
  logic [3:0] sel_op;

  function automatic logic is_slow(input logic [3:0] op);
    return (op == 4'd9) || (op == 4'd12) || (op == 4'd13);
  endfunction

  function automatic logic is_unsup(input logic [3:0] op);
    return (op == 4'd5) || (op == 4'd15);
  endfunction

  // fav1 set means requester 1 wins a tie; requester 0 always wins otherwise.
  always_comb begin
    grant1    = ReqValid1 && (!ReqValid0 || fav1);
    ReqReady0 = Rst && (state == IDLE) && ReqValid0 && !grant1;
    ReqReady1 = Rst && (state == IDLE) && grant1;
    take      = ReqReady0 || ReqReady1;
    sel_op    = grant1 ? ReqOp1 : ReqOp0;
    RspValid  = (state == RESP);
    Busy      = (state != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      fav1          <= 1'b0;
      ALUControlOut <= 4'd0;
      AOut          <= 32'd0;
      BOut          <= 32'd0;
      Result        <= 32'd0;
      Zero          <= 1'b1;
      RspId         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            ALUControlOut <= sel_op;
            AOut          <= grant1 ? ReqA1 : ReqA0;
            BOut          <= grant1 ? ReqB1 : ReqB0;
            RspId         <= grant1;
            fav1          <= !grant1;
            cnt           <= is_slow(sel_op) ? SLOW_LOAD : 4'd0;
            state         <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            Result <= is_unsup(ALUControlOut) ? 32'd0 : ALUResultIn;
            Zero   <= is_unsup(ALUControlOut) ? 1'b1  : ZeroIn;
            state  <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (RspReady) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: reference ALU on the shared port, arbitration model,
// and a response scoreboard checked on the falling edge.
module tb_alu_arbiter;

  localparam int SLOW_LAT = 3;

  logic        Clk, Rst;
  logic        ReqValid0, ReqValid1, ReqReady0, ReqReady1;
  logic [3:0]  ReqOp0, ReqOp1, ALUControlOut;
  logic [31:0] ReqA0, ReqB0, ReqA1, ReqB1, AOut, BOut, ALUResultIn, Result;
  logic        ZeroIn, RspValid, RspReady, RspId, Zero, Busy;

  alu_arbiter #(.SLOW_LAT(SLOW_LAT)) dut (
    .Clk(Clk), .Rst(Rst),
    .ReqValid0(ReqValid0), .ReqValid1(ReqValid1),
    .ReqReady0(ReqReady0), .ReqReady1(ReqReady1),
    .ReqOp0(ReqOp0), .ReqOp1(ReqOp1),
    .ReqA0(ReqA0), .ReqB0(ReqB0), .ReqA1(ReqA1), .ReqB1(ReqB1),
    .ALUControlOut(ALUControlOut), .AOut(AOut), .BOut(BOut),
    .ALUResultIn(ALUResultIn), .ZeroIn(ZeroIn),
    .RspValid(RspValid), .RspReady(RspReady), .RspId(RspId),
    .Result(Result), .Zero(Zero), .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        id;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    int          lat;
  } exp_t;

  exp_t        q[$];
  logic        rsp_id_q[$];
  logic [31:0] rsp_res_q[$];
  logic        rsp_zero_q[$];

  int   n_chk = 0;
  int   n_fail = 0;
  int   acc_count = 0;
  int   cyc = 0;
  bit   seen = 0;
  bit   model_idle = 1;
  bit   idle_next = 0;
  bit   fav1 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Unsupported codes return junk so that passing it through would be noticed.
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    bit          found;
    int          sh;
    r = 32'hDEAD_BEEF;
    found = 0;
    sh = int'(a[4:0]);
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd3:  r = ~(a | b);
      4'd4:  r = a ^ b;
      4'd6:  r = a - b;
      4'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:  r = a;
      4'd9:  r = a * b;
      4'd10: r = b << sh;
      4'd11: r = ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
      4'd12: begin
        r = 32'd0;
        for (int i = 31; i >= 0; i--)
          if (!found) begin
            if (a[i]) found = 1;
            else r = r + 32'd1;
          end
      end
      4'd13: r = (b >> sh) | (b << (32 - sh));
      4'd14: r = (a < b) ? 32'd1 : 32'd0;
      default: r = 32'hDEAD_BEEF;
    endcase
    return r;
  endfunction

  always_comb begin
    ALUResultIn = alu_ref(ALUControlOut, AOut, BOut);
    ZeroIn      = (ALUResultIn == 32'd0);
  end

  always @(negedge Clk) begin
    exp_t e;
    bit   g0, g1;
    if (!Rst) begin
      chk("rst_rdy0", 32'(ReqReady0), 32'd0);
      chk("rst_rdy1", 32'(ReqReady1), 32'd0);
      q.delete();
      model_idle = 1;
      idle_next  = 0;
      fav1       = 0;
      seen       = 0;
      cyc        = 0;
    end else begin
      if (idle_next) begin
        model_idle = 1;
        idle_next  = 0;
        chk("busy_clr", 32'(Busy), 32'd0);
      end
      if (q.size() > 0) begin
        e = q[0];
        cyc++;
        if (!RspValid) begin
          chk("hold_op", 32'(ALUControlOut), 32'(e.op));
          chk("hold_a", AOut, e.a);
          chk("hold_b", BOut, e.b);
          chk("exec_busy", 32'(Busy), 32'd1);
          if (cyc == e.lat) chk("rsp_missing", 32'(RspValid), 32'd1);
        end else begin
          if (!seen) chk("rsp_lat", 32'(cyc), 32'(e.lat));
          seen = 1;
          chk("rsp_res", Result, e.res);
          chk("rsp_zero", 32'(Zero), 32'(e.zero));
          chk("rsp_id", 32'(RspId), 32'(e.id));
          if (RspReady) begin
            void'(q.pop_front());
            rsp_id_q.push_back(RspId);
            rsp_res_q.push_back(Result);
            rsp_zero_q.push_back(Zero);
            idle_next = 1;
          end
        end
      end else if (RspValid) begin
        chk("spurious_rsp", 32'(RspValid), 32'd0);
      end
      if (model_idle) begin
        g0 = ReqValid0 && (!ReqValid1 || !fav1);
        g1 = ReqValid1 && !g0;
        chk("grant0", 32'(ReqReady0), 32'(g0));
        chk("grant1", 32'(ReqReady1), 32'(g1));
        if (g0 || g1) begin
          e.id = g1;
          e.op = g1 ? ReqOp1 : ReqOp0;
          e.a  = g1 ? ReqA1 : ReqA0;
          e.b  = g1 ? ReqB1 : ReqB0;
          if (e.op == 4'd5 || e.op == 4'd15) begin
            e.res  = 32'd0;
            e.zero = 1'b1;
          end else begin
            e.res  = alu_ref(e.op, e.a, e.b);
            e.zero = (e.res == 32'd0);
          end
          e.lat = (e.op == 4'd9 || e.op == 4'd12 || e.op == 4'd13) ? SLOW_LAT + 1 : 2;
          q.push_back(e);
          fav1       = g0;
          model_idle = 0;
          cyc        = 0;
          seen       = 0;
          acc_count++;
        end
      end
    end
  end

  task automatic issue(input bit id, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    int base = acc_count;
    bit got = 0;
    if (id == 1'b0) begin
      ReqOp0 = op; ReqA0 = a; ReqB0 = b; ReqValid0 = 1'b1;
    end else begin
      ReqOp1 = op; ReqA1 = a; ReqB1 = b; ReqValid1 = 1'b1;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge Clk); #1;
      if (acc_count != base) got = 1;
    end
    ReqValid0 = 1'b0;
    ReqValid1 = 1'b0;
    chk("accept_timeout", 32'(got), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge Clk); #1;
      if (rnd) RspReady = 1'($urandom_range(0, 1));
      if (model_idle && q.size() == 0) done = 1;
    end
    RspReady = 1'b1;
    chk("idle_timeout", 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_op"}, 32'(ALUControlOut), 32'd0);
    chk({tag, "_a"}, AOut, 32'd0);
    chk({tag, "_b"}, BOut, 32'd0);
    chk({tag, "_res"}, Result, 32'd0);
    chk({tag, "_zero"}, 32'(Zero), 32'd1);
    chk({tag, "_id"}, 32'(RspId), 32'd0);
    chk({tag, "_valid"}, 32'(RspValid), 32'd0);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    int  n, base;
    bit  got;
    Rst = 1'b0;
    ReqValid0 = 1'b1; ReqValid1 = 1'b1;
    ReqOp0 = 4'd2; ReqOp1 = 4'd2;
    ReqA0 = 32'd1; ReqB0 = 32'd1; ReqA1 = 32'd1; ReqB1 = 32'd1;
    RspReady = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk_reset_vals("reset");
    ReqValid0 = 1'b0; ReqValid1 = 1'b0;
    Rst = 1'b1;

    issue(1'b0, 4'd2, 32'd5, 32'd7);
    wait_idle(20, 0);
    n = rsp_res_q.size();
    chk("add_count", 32'(n), 32'd1);
    if (n > 0) begin
      chk("add_res", rsp_res_q[n-1], 32'd12);
      chk("add_zero", 32'(rsp_zero_q[n-1]), 32'd0);
      chk("add_id", 32'(rsp_id_q[n-1]), 32'd0);
    end

    do_reset();
    ReqOp0 = 4'd6; ReqA0 = 32'd9;    ReqB0 = 32'd9;
    ReqOp1 = 4'd0; ReqA1 = 32'hF0;   ReqB1 = 32'h0F;
    ReqValid0 = 1'b1; ReqValid1 = 1'b1;
    base = acc_count;
    n = rsp_id_q.size();
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge Clk); #1;
      if (acc_count - base >= 3) got = 1;
    end
    ReqValid0 = 1'b0; ReqValid1 = 1'b0;
    chk("cont_timeout", 32'(got), 32'd1);
    wait_idle(20, 0);
    chk("cont_count", 32'(rsp_id_q.size() - n), 32'd3);
    if (rsp_id_q.size() >= n + 3) begin
      chk("cont_id0", 32'(rsp_id_q[n]), 32'd0);
      chk("cont_id1", 32'(rsp_id_q[n+1]), 32'd1);
      chk("cont_id2", 32'(rsp_id_q[n+2]), 32'd0);
      chk("cont_res1", rsp_res_q[n+1], 32'd0);
      chk("cont_zero1", 32'(rsp_zero_q[n+1]), 32'd1);
    end

    issue(1'b1, 4'd9, 32'd3, 32'd4);
    wait_idle(20, 0);
    n = rsp_res_q.size();
    chk("mul_res", rsp_res_q[n-1], 32'd12);

    issue(1'b0, 4'd15, 32'd1, 32'd1);
    wait_idle(20, 0);
    n = rsp_res_q.size();
    chk("unsup_res", rsp_res_q[n-1], 32'd0);
    chk("unsup_zero", 32'(rsp_zero_q[n-1]), 32'd1);

    RspReady = 1'b0;
    issue(1'b0, 4'd2, 32'h10, 32'h20);
    ReqOp1 = 4'd1; ReqA1 = 32'd3; ReqB1 = 32'd4; ReqValid1 = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (RspValid) got = 1;
      else begin @(posedge Clk); #1; end
    end
    chk("bp_timeout", 32'(got), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      chk("bp_valid", 32'(RspValid), 32'd1);
      chk("bp_res", Result, 32'h30);
      chk("bp_id", 32'(RspId), 32'd0);
      chk("bp_rdy0", 32'(ReqReady0), 32'd0);
      chk("bp_rdy1", 32'(ReqReady1), 32'd0);
    end
    ReqValid1 = 1'b0;
    RspReady = 1'b1;
    wait_idle(10, 0);

    n = rsp_res_q.size();
    issue(1'b0, 4'd9, 32'd6, 32'd7);
    Rst = 1'b0;
    ReqValid0 = 1'b1;
    @(posedge Clk); #1;
    chk_reset_vals("midrst");
    ReqValid0 = 1'b0;
    Rst = 1'b1;
    repeat (8) @(posedge Clk);
    #1;
    chk("abandon_count", 32'(rsp_res_q.size()), 32'(n));

    for (int k = 0; k < 25; k++) begin
      issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom);
      wait_idle(40, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
